// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//
// Instruction-fetch stage that sits directly downstream of the program counter.
// Each cycle it reads the PC and fetches 16-bit words from instruction memory
// through a same-cycle ready handshake. It assembles one- or two-word
// instructions into the IF/ID pipeline register. It tells the PC when to advance
// and by how many words. Decode-side stall and branch/interrupt flush are obeyed.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   pc           current PC, stable at posedge
//   imem_rdata   instruction word, valid when imem_ready=1
//   imem_ready   memory returned data for the current request, same cycle
//   stall        IF/ID register must hold its contents
//   flush        discard the in-flight fetch and the IF/ID contents
//   imem_req     read request
//   imem_addr    word address of the request
//   pc_hold      1 = PC must not advance this cycle
//   pc_step      advance amount when pc_hold=0 (1 or 2 words)
//   instr        IF/ID instruction {word0, word1}; word1=0 for short instructions
//   instr_pc     PC of the instruction in IF/ID
//   instr_valid  IF/ID holds a real instruction (0 = bubble)

module if_fetch_unit #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned LONG_BIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              pc_hold,
    output logic [1:0]        pc_step,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid
);

    typedef enum logic [1:0] {
        StW0   = 2'd0,
        StW1   = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Partial long instruction: first word and its PC.
    logic [15:0] word0_q, word0_d;
    logic [31:0] fpc_q, fpc_d;

    // Completed instruction parked while decode is stalled.
    logic [31:0] park_instr_q, park_instr_d;
    logic [31:0] park_pc_q, park_pc_d;
    logic        park_long_q, park_long_d;

    // IF/ID pipeline register.
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    // Unqualified (pre-reset-gating) combinational outputs.
    logic              req_c;
    logic [ADDR_W-1:0] addr_c;
    logic              hold_c;
    logic [1:0]        step_c;

    // Instruction finished assembling this cycle.
    logic        done;
    logic [31:0] done_instr;
    logic [31:0] done_pc;
    logic        done_long;

    // Second-word address wraps naturally at ADDR_W bits.
    logic [ADDR_W-1:0] w1_addr;
    assign w1_addr = fpc_q[ADDR_W-1:0] + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        word0_d      = word0_q;
        fpc_d        = fpc_q;
        park_instr_d = park_instr_q;
        park_pc_d    = park_pc_q;
        park_long_d  = park_long_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        // Without a transfer, a non-stalled IF/ID drains to a bubble.
        instr_valid_d = stall ? instr_valid_q : 1'b0;

        req_c  = 1'b0;
        addr_c = pc[ADDR_W-1:0];
        hold_c = 1'b1;
        step_c = 2'd1;

        done       = 1'b0;
        done_instr = 32'h0;
        done_pc    = 32'h0;
        done_long  = 1'b0;

        if (flush) begin
            // Flush beats stall and any memory response this cycle.
            instr_valid_d = 1'b0;
            state_d       = StW0;
            word0_d       = 16'h0;
            fpc_d         = 32'h0;
            park_instr_d  = 32'h0;
            park_pc_d     = 32'h0;
            park_long_d   = 1'b0;
        end else begin
            case (state_q)
                StW0: begin
                    req_c  = 1'b1;
                    addr_c = pc[ADDR_W-1:0];
                    if (imem_ready) begin
                        if (imem_rdata[LONG_BIT]) begin
                            word0_d = imem_rdata;
                            fpc_d   = pc;
                            state_d = StW1;
                        end else begin
                            done       = 1'b1;
                            done_instr = {imem_rdata, 16'h0000};
                            done_pc    = pc;
                            done_long  = 1'b0;
                        end
                    end
                end
                StW1: begin
                    req_c  = 1'b1;
                    addr_c = w1_addr;
                    if (imem_ready) begin
                        done       = 1'b1;
                        done_instr = {word0_q, imem_rdata};
                        done_pc    = fpc_q;
                        done_long  = 1'b1;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        instr_d       = park_instr_q;
                        instr_pc_d    = park_pc_q;
                        instr_valid_d = 1'b1;
                        hold_c        = 1'b0;
                        step_c        = park_long_q ? 2'd2 : 2'd1;
                        state_d       = StW0;
                    end
                end
                default: begin
                    state_d = StW0;
                end
            endcase

            if (done) begin
                if (!stall) begin
                    instr_d       = done_instr;
                    instr_pc_d    = done_pc;
                    instr_valid_d = 1'b1;
                    hold_c        = 1'b0;
                    step_c        = done_long ? 2'd2 : 2'd1;
                    state_d       = StW0;
                end else begin
                    // PC stays put until the parked instruction is handed over.
                    park_instr_d = done_instr;
                    park_pc_d    = done_pc;
                    park_long_d  = done_long;
                    state_d      = StHold;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StW0;
            word0_q       <= 16'h0;
            fpc_q         <= 32'h0;
            park_instr_q  <= 32'h0;
            park_pc_q     <= 32'h0;
            park_long_q   <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word0_q       <= word0_d;
            fpc_q         <= fpc_d;
            park_instr_q  <= park_instr_d;
            park_pc_q     <= park_pc_d;
            park_long_q   <= park_long_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Reset forces the PC-facing handshake idle immediately, not at the next edge.
    assign imem_req    = reset & req_c;
    assign imem_addr   = addr_c;
    assign pc_hold     = ~reset | hold_c;
    assign pc_step     = (reset & ~hold_c) ? step_c : 2'd1;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [19:0] imem_addr;
    logic        pc_hold;
    logic [1:0]  pc_step;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W   (20),
        .LONG_BIT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc_hold     (pc_hold),
        .pc_step     (pc_step),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    // One record per clock cycle: inputs for the cycle, expected combinational
    // outputs before the edge, expected IF/ID contents after the edge.
    typedef struct {
        logic [31:0] pc;
        logic [15:0] rdata;
        logic        ready;
        logic        stall;
        logic        flush;
        logic        e_req;
        logic        chk_addr;
        logic [19:0] e_addr;
        logic        e_hold;
        logic [1:0]  e_step;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic [15:0] rd, input logic rdy,
                       input logic st, input logic fl, input logic e_req, input logic ca,
                       input logic [19:0] e_addr, input logic e_hold, input logic [1:0] e_step,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc,
                       input logic e_valid);
        vec_t v;
        v.pc = p; v.rdata = rd; v.ready = rdy; v.stall = st; v.flush = fl;
        v.e_req = e_req; v.chk_addr = ca; v.e_addr = e_addr; v.e_hold = e_hold;
        v.e_step = e_step; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    initial begin
        reset      = 1'b0;
        pc         = 32'h0;
        imem_rdata = 16'h0;
        imem_ready = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;

        //   pc            rdata     rdy st fl  req ca addr       hld stp instr         ipc           v
        // Short fetch, no waits.
        add(32'd32,        16'h1234, 1, 0, 0,  1, 1, 20'd32,    0, 1, 32'h12340000, 32'd32,       1);
        // Long fetch, one wait on word1.
        add(32'd40,        16'h8A01, 1, 0, 0,  1, 1, 20'd40,    1, 1, 32'h12340000, 32'd32,       0);
        add(32'd40,        16'h0000, 0, 0, 0,  1, 1, 20'd41,    1, 1, 32'h12340000, 32'd32,       0);
        add(32'd40,        16'h00FF, 1, 0, 0,  1, 1, 20'd41,    0, 2, 32'h8A0100FF, 32'd40,       1);
        // Short instruction completes under a three-cycle stall.
        add(32'd42,        16'h0042, 1, 1, 0,  1, 1, 20'd42,    1, 1, 32'h8A0100FF, 32'd40,       1);
        add(32'd42,        16'h7777, 1, 1, 0,  0, 0, 20'd0,     1, 1, 32'h8A0100FF, 32'd40,       1);
        add(32'd42,        16'h7777, 1, 1, 0,  0, 0, 20'd0,     1, 1, 32'h8A0100FF, 32'd40,       1);
        add(32'd42,        16'h0000, 0, 0, 0,  0, 0, 20'd0,     0, 1, 32'h00420000, 32'd42,       1);
        // Flush in S_W1 with a response present; refetch from pc=0.
        add(32'd43,        16'h8123, 1, 0, 0,  1, 1, 20'd43,    1, 1, 32'h00420000, 32'd42,       0);
        add(32'd43,        16'h5555, 1, 0, 1,  0, 0, 20'd0,     1, 1, 32'h00420000, 32'd42,       0);
        add(32'd0,         16'h0007, 1, 0, 0,  1, 1, 20'd0,     0, 1, 32'h00070000, 32'd0,        1);
        // Flush together with stall: flush wins.
        add(32'd1,         16'h0001, 1, 1, 1,  0, 0, 20'd0,     1, 1, 32'h00070000, 32'd0,        0);
        // Wait state on a short fetch.
        add(32'd1,         16'h0000, 0, 0, 0,  1, 1, 20'd1,     1, 1, 32'h00070000, 32'd0,        0);
        add(32'd1,         16'h0009, 1, 0, 0,  1, 1, 20'd1,     0, 1, 32'h00090000, 32'd1,        1);
        // Stall with nothing completing keeps valid; release drains to a bubble.
        add(32'd2,         16'h0000, 0, 1, 0,  1, 1, 20'd2,     1, 1, 32'h00090000, 32'd1,        1);
        add(32'd2,         16'h0000, 0, 0, 0,  1, 1, 20'd2,     1, 1, 32'h00090000, 32'd1,        0);
        // Address wrap on the second word.
        add(32'h000FFFFF,  16'h8001, 1, 0, 0,  1, 1, 20'hFFFFF, 1, 1, 32'h00090000, 32'd1,        0);
        add(32'h000FFFFF,  16'hABCD, 1, 0, 0,  1, 1, 20'h00000, 0, 2, 32'h8001ABCD, 32'h000FFFFF, 1);
        // Parked instruction discarded by flush.
        add(32'h200,       16'h0011, 1, 1, 0,  1, 1, 20'h200,   1, 1, 32'h8001ABCD, 32'h000FFFFF, 1);
        add(32'h200,       16'h0000, 0, 0, 1,  0, 0, 20'd0,     1, 1, 32'h8001ABCD, 32'h000FFFFF, 0);
        add(32'h300,       16'h0022, 1, 0, 0,  1, 1, 20'h300,   0, 1, 32'h00220000, 32'h300,      1);
        // Long instruction completes under stall, released with pc_step=2.
        add(32'h301,       16'h8033, 1, 0, 0,  1, 1, 20'h301,   1, 1, 32'h00220000, 32'h300,      0);
        add(32'h301,       16'h0044, 1, 1, 0,  1, 1, 20'h302,   1, 1, 32'h00220000, 32'h300,      0);
        add(32'h301,       16'h0000, 0, 0, 0,  0, 0, 20'd0,     0, 2, 32'h80330044, 32'h301,      1);

        // Reset state while reset is held.
        #1;
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_hold",  {31'h0, pc_hold},     32'h1);
        chk("rst_step",  {30'h0, pc_step},     32'h1);
        chk("rst_instr", instr,                32'h0);
        chk("rst_ipc",   instr_pc,             32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pc         = vecs[i].pc;
            imem_rdata = vecs[i].rdata;
            imem_ready = vecs[i].ready;
            stall      = vecs[i].stall;
            flush      = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d_addr", i), {12'h0, imem_addr}, {12'h0, vecs[i].e_addr});
            chk($sformatf("v%0d_hold", i), {31'h0, pc_hold}, {31'h0, vecs[i].e_hold});
            chk($sformatf("v%0d_step", i), {30'h0, pc_step}, {30'h0, vecs[i].e_step});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            chk($sformatf("v%0d_ipc", i), instr_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
        end

        // Asynchronous reset in S_W1 with a valid instruction held in IF/ID.
        @(negedge clk);
        pc         = 32'h500;
        imem_rdata = 16'h8055;
        imem_ready = 1'b1;
        stall      = 1'b1;
        flush      = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_pre_valid", {31'h0, instr_valid}, 32'h1);
        imem_ready = 1'b0;
        #1;
        chk("ar_pre_addr", {12'h0, imem_addr}, 32'h501);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid", {31'h0, instr_valid}, 32'h0);
        chk("ar_req",   {31'h0, imem_req},    32'h0);
        chk("ar_hold",  {31'h0, pc_hold},     32'h1);
        chk("ar_step",  {30'h0, pc_step},     32'h1);
        chk("ar_instr", instr,                32'h0);
        chk("ar_ipc",   instr_pc,             32'h0);
        @(negedge clk);
        pc    = 32'h600;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 16'h0066;
        #1;
        chk("ar_post_req",  {31'h0, imem_req},  32'h1);
        chk("ar_post_addr", {12'h0, imem_addr}, 32'h600);
        chk("ar_post_hold", {31'h0, pc_hold},   32'h0);
        chk("ar_post_step", {30'h0, pc_step},   32'h1);
        @(posedge clk);
        #1;
        chk("ar_post_instr", instr,                32'h00660000);
        chk("ar_post_ipc",   instr_pc,             32'h600);
        chk("ar_post_valid", {31'h0, instr_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter. Each cycle it reads the PC value and fetches 16-bit words from instruction memory through a ready handshake.
- It assembles one- or two-word instructions and loads them into the IF/ID pipeline register.
- It tells the PC when to advance, and by how many words. It obeys decode-side stall and branch/interrupt flush.

Parameters:
- ADDR_W, 20, instruction-memory word-address width; the fetch address is the low ADDR_W bits of the PC.
- LONG_BIT, 15, bit of the first word that marks a two-word instruction (1 = immediate word follows).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pc  input  32  current PC; stable at posedge.
- imem_rdata  input  16  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory has returned data for the current imem_req/imem_addr, same cycle.
- stall  input  1  IF/ID register must hold its contents.
- flush  input  1  discard the in-flight fetch and the IF/ID contents.
- imem_req  output  1  read request.
- imem_addr  output  ADDR_W  word address of the request.
- pc_hold  output  1  1 = PC must not advance this cycle.
- pc_step  output  2  advance amount when pc_hold=0: 2'd1 or 2'd2.
- instr  output  32  IF/ID instruction {word0, word1}; word1 = 16'h0000 for short instructions.
- instr_pc  output  32  PC of the instruction in IF/ID.
- instr_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_W0.
  - instr=0, instr_pc=0, instr_valid=0.
  - Internal word0 and fpc registers cleared.
  - While reset is asserted: imem_req=0, pc_hold=1, pc_step=1.
- States:
  - S_W0:
    - imem_req=1, imem_addr=pc[ADDR_W-1:0].
    - On imem_ready, if imem_rdata[LONG_BIT]=1: latch word0<=imem_rdata and fpc<=pc, then go to S_W1.
    - On imem_ready, if imem_rdata[LONG_BIT]=0: the instruction is complete this cycle with word1=0.
    - With no ready: stay in S_W0.
  - S_W1:
    - imem_req=1, imem_addr=(fpc+1) truncated to ADDR_W. The address wraps from all-ones to 0.
    - On imem_ready the instruction {word0, imem_rdata} is complete.
    - With no ready: stay in S_W1.
  - S_HOLD:
    - imem_req=0. The assembled instruction is parked in internal registers.
    - When stall=0: transfer it to IF/ID, then go to S_W0.
- Completion cycle:
  - If stall=0: load IF/ID (instr, instr_pc = pc for short / fpc for long, instr_valid=1), then go to S_W0.
  - If stall=1: save the instruction, PC and length internally, then go to S_HOLD. IF/ID is unchanged.
- PC control:
  - pc_hold=0 only in the cycle an instruction is transferred into IF/ID (a completion with stall=0, or S_HOLD with stall=0). Otherwise pc_hold=1.
  - pc_step = 2 for a long instruction, 1 for a short one. pc_step=1 whenever pc_hold=1.
  - The PC updates on negedge, so the new value is valid at the next posedge.
- IF/ID register:
  - When stall=1: all of instr, instr_pc and instr_valid hold.
  - When stall=0 and no transfer occurs: instr_valid<=0. instr and instr_pc hold their values (bubble).
- Flush (synchronous, priority over every other event):
  - instr_valid<=0; any latched word0 or parked instruction is discarded; state<=S_W0.
  - imem_req=0 and pc_hold=1 in the flush cycle. A memory response arriving in that cycle is ignored.
  - Fetching resumes next cycle from the redirected pc.
- Flush together with stall: flush wins and instr_valid<=0.
- Reset mid-fetch: the partial instruction is lost, and operation restarts in S_W0 after reset deasserts.
- imem_req is never asserted in S_HOLD. The address is combinational from state, pc and fpc.
- Latency: with zero wait states, a short instruction reaches IF/ID 1 cycle after pc is presented and a long one after 2 cycles. Each wait cycle adds 1.

Test Plan:
- Short fetch, no waits: pc=32, imem_ready=1, rdata=16'h1234 -> next posedge instr=32'h12340000, instr_pc=32, instr_valid=1; pc_hold=0, pc_step=1 in the completion cycle.
- Long fetch with one wait on word1: pc=40, rdata word0=16'h8A01, word1 ready one cycle late with 16'h00FF -> instr=32'h8A0100FF, instr_pc=40 after 3 cycles; imem_addr=41 in S_W1; pc_step=2 only in the completion cycle; pc_hold=1 in the two earlier cycles.
- Stall at completion: short instruction 16'h0042 completes while stall=1 for 3 cycles -> IF/ID unchanged and imem_req=0 during the stall; on stall=0, instr=32'h00420000, instr_valid=1, pc_hold=0 that cycle.
- Flush mid long fetch: in S_W1 assert flush with imem_ready=1 -> instr_valid=0 next cycle, word discarded, state S_W0, next fetch at the new pc=0.
- Address wrap: long instruction at pc=20'hFFFFF -> second request at imem_addr=0 and instr_pc=32'h000FFFFF.
- Async reset mid-fetch: drop reset in S_W1 between clock edges -> instr_valid=0 and imem_req=0 immediately; first request after release at imem_addr=pc.
